binary_search_param: RTL and testbench

BINARY_SEARCH_PARAM -- requirements
Module: binary_search_param

---
 rtl/binary_search_pkg.sv | 14 +
 rtl/search_mem.sv | 24 ++
 rtl/binary_search_param.sv | 142 ++++++++++++++
 tb/tb_binary_search_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_search_pkg.sv
// rtl/binary_search_pkg.sv - Shared state encoding and default sizing for the binary search block
package binary_search_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/search_mem.sv
// rtl/search_mem.sv - DEPTH x DATA_W memory, one write port and one registered read port
module search_mem
    import binary_search_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/binary_search_param.sv
// rtl/binary_search_param.sv - Exact-match / lower-bound binary search over a loadable sorted memory
module binary_search_param
    import binary_search_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Key,
    input  logic              Mode,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Found,
    output logic [ADDR_W:0]   Index,
    output logic [ADDR_W:0]   Probes
);
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              mode_q, mode_d;
    logic [IDX_W-1:0]  lo_q, lo_d, hi_q, hi_d, mid_q, mid_d;
    logic [IDX_W-1:0]  lo_n, hi_n, mid_c;
    logic [IDX_W:0]    sum;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  index_q, index_d, probes_q, probes_d;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;

    assign sum    = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid_c  = IDX_W'(sum >> 1);
    assign Busy   = (state_q != S_IDLE);
    assign Done   = (state_q == S_DONE);
    assign Found  = found_q;
    assign Index  = index_q;
    assign Probes = probes_q;
    assign mem_we = Wr_En && !Busy && !Reset;

    search_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (Clock),
        .wr_en   (mem_we),
        .wr_addr (Wr_Addr),
        .wr_data (Wr_Data),
        .rd_addr (mid_c[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        mode_d   = mode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        mid_d    = mid_q;
        found_d  = found_q;
        index_d  = index_q;
        probes_d = probes_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        if (rd_data < key_q) begin
            lo_n = mid_q + IDX_W'(1);
        end else begin
            hi_n = mid_q;
        end
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    key_d    = Key;
                    mode_d   = Mode;
                    lo_d     = '0;
                    hi_d     = DEPTH_V;
                    found_d  = 1'b0;
                    index_d  = '0;
                    probes_d = '0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (lo_q >= hi_q) begin
                    index_d = lo_q;
                    found_d = mode_q && (lo_q < DEPTH_V);
                    state_d = S_DONE;
                end else begin
                    mid_d    = mid_c;
                    probes_d = probes_q + IDX_W'(1);
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                if (!mode_q && (rd_data == key_q)) begin
                    found_d = 1'b1;
                    index_d = mid_q;
                    state_d = S_DONE;
                end else begin
                    lo_d = lo_n;
                    hi_d = hi_n;
                    // Leave straight from CMP when the interval empties so Done lands on cycle 2*Probes+1
                    if (lo_n >= hi_n) begin
                        index_d = lo_n;
                        found_d = mode_q && (lo_n < DEPTH_V);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            mode_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            mid_q    <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            mode_q   <= mode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            mid_q    <= mid_d;
            found_q  <= found_d;
            index_q  <= index_d;
            probes_q <= probes_d;
        end
    end

endmodule

// File: tb/tb_binary_search_param.sv
// tb/tb_binary_search_param.sv - Scoreboard bench for binary_search_param with a behavioural search model
module tb_binary_search_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              Clock = 1'b0;
    logic              Reset, Start, Mode, Wr_En;
    logic [DATA_W-1:0] Key, Wr_Data;
    logic [ADDR_W-1:0] Wr_Addr;
    logic              Busy, Done, Found;
    logic [ADDR_W:0]   Index, Probes;

    typedef struct {
        logic  found;
        int    index;
        int    probes;
        int    done_cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   ref_mem[DEPTH];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    binary_search_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Key     (Key),
        .Mode    (Mode),
        .Wr_En   (Wr_En),
        .Wr_Addr (Wr_Addr),
        .Wr_Data (Wr_Data),
        .Busy    (Busy),
        .Done    (Done),
        .Found   (Found),
        .Index   (Index),
        .Probes  (Probes)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: lower bound by counting smaller entries; probe count by halving an integer interval
    task automatic model(input int key, input bit mode, output bit f, output int idx, output int pr);
        int lb, lo, hi, m;
        lb = 0;
        for (int i = 0; i < DEPTH; i++) if (ref_mem[i] < key) lb++;
        idx = lb;
        f = mode ? (lb < DEPTH) : ((lb < DEPTH) && (ref_mem[lb] == key));
        pr = 0; lo = 0; hi = DEPTH;
        while (lo < hi) begin
            m = (lo + hi) / 2;
            pr++;
            if (!mode && ref_mem[m] == key) break;
            if (ref_mem[m] < key) lo = m + 1; else hi = m;
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(Done), 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_found"},   32'(Found),  32'(e.found));
                chk({e.name, "_index"},   32'(Index),  e.index);
                chk({e.name, "_probes"},  32'(Probes), e.probes);
                chk({e.name, "_latency"}, cyc,         e.done_cyc);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 100) begin @(negedge Clock); n++; end
        if (Busy) chk({name, "_idle_timeout"}, 32'(Busy), 0);
    endtask

    task automatic issue(input int key, input bit mode, input bit ef, input int ei, input int ep,
                         input bit expect_done, input string name);
        exp_t e;
        wait_idle(name);
        Start = 1'b1; Key = key[DATA_W-1:0]; Mode = mode;
        @(posedge Clock); #1;
        Start = 1'b0;
        chk({name, "_busy"}, 32'(Busy), 1);
        if (expect_done) begin
            e.found = ef; e.index = ei; e.probes = ep; e.done_cyc = cyc + 2 * ep; e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge Clock); n++; end
        if (sb.size() != 0) begin
            chk({name, "_done_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_search(input int key, input bit mode, input bit ef, input int ei, input int ep,
                             input string name);
        issue(key, mode, ef, ei, ep, 1'b1, name);
        drain(name);
        @(negedge Clock); @(negedge Clock);
        chk({name, "_hold_found"}, 32'(Found), 32'(ef));
        chk({name, "_hold_index"}, 32'(Index), ei);
    endtask

    task automatic write_word(input int addr, input int data);
        wait_idle("write");
        Wr_En = 1'b1; Wr_Addr = addr[ADDR_W-1:0]; Wr_Data = data[DATA_W-1:0];
        @(posedge Clock); #1;
        Wr_En = 1'b0;
        ref_mem[addr] = data;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit f;
        int idx, pr, key, v;
        bit mode;
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Key = '0;
        Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        repeat (3) @(negedge Clock);
        chk("rst_busy",   32'(Busy),   0);
        chk("rst_done",   32'(Done),   0);
        chk("rst_found",  32'(Found),  0);
        chk("rst_index",  32'(Index),  0);
        chk("rst_probes", 32'(Probes), 0);
        Reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) write_word(i, 2 * i + 1);

        do_search(33, 1'b0, 1'b1, 16, 1, "exact_hit33");
        do_search(32, 1'b0, 1'b0, 16, 5, "exact_miss32");
        do_search(0,  1'b1, 1'b1, 0,  6, "lb_key0");
        do_search(64, 1'b1, 1'b0, 32, 5, "lb_key64");

        // Second Start and a write while busy must both be dropped
        issue(32, 1'b0, 1'b0, 16, 5, 1'b1, "busy_ignore");
        repeat (3) @(negedge Clock);
        Start = 1'b1; Key = 8'd1; Mode = 1'b0;
        Wr_En = 1'b1; Wr_Addr = 5'd16; Wr_Data = 8'd0;
        @(negedge Clock);
        Start = 1'b0; Wr_En = 1'b0;
        drain("busy_ignore");
        do_search(33, 1'b0, 1'b1, 16, 1, "mem16_kept");

        // Write and Start in the same idle cycle: the search sees the new word
        wait_idle("wr_start");
        Wr_En = 1'b1; Wr_Addr = 5'd16; Wr_Data = 8'd34;
        ref_mem[16] = 34;
        issue(34, 1'b0, 1'b1, 16, 1, 1'b1, "wr_start_same");
        Wr_En = 1'b0;
        drain("wr_start_same");
        write_word(16, 33);

        // Reset landing in CMP aborts the search with no Done
        issue(10, 1'b0, 1'b0, 0, 0, 1'b0, "abort");
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort_busy",   32'(Busy),   0);
        chk("abort_done",   32'(Done),   0);
        chk("abort_found",  32'(Found),  0);
        chk("abort_index",  32'(Index),  0);
        chk("abort_probes", 32'(Probes), 0);
        repeat (12) @(negedge Clock);
        do_search(63, 1'b0, 1'b1, 31, 5, "after_abort63");

        for (int r = 0; r < 3; r++) begin
            v = $urandom_range(20, 0);
            for (int i = 0; i < DEPTH; i++) begin
                write_word(i, v);
                v += $urandom_range(7, 1);
            end
            for (int s = 0; s < 10; s++) begin
                mode = 1'($urandom_range(1, 0));
                if ($urandom_range(1, 0) == 1) key = ref_mem[$urandom_range(DEPTH - 1, 0)];
                else key = $urandom_range(255, 0);
                model(key, mode, f, idx, pr);
                issue(key, mode, f, idx, pr, 1'b1, $sformatf("rnd_r%0d_s%0d", r, s));
                drain("rnd");
            end
        end

        repeat (4) @(negedge Clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
